des_key_scheduler: RTL and testbench
====================================

Name: des_key_scheduler

Overview:
- Sequences the DES key schedule for the descrypt cores.
- Accepts one 64-bit key per job, applies PC-1 internally, then rotates the 28-bit C/D halves round by round.
- Streams the 16 PC-2 round subkeys, with handshake, to the round datapath.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1) per key.

Parameters:
- none. Round count (16), the shift table and the PC-1/PC-2 tables are fixed by the DES standard.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET_N  in  1  synchronous reset, active-low
- key_in  in  64  DES key; bit 63 = DES bit 1 (MSB-first); parity bits ignored
- key_decrypt  in  1  0 = encrypt order, 1 = decrypt order; sampled with key_in
- key_valid  in  1  key_in/key_decrypt valid
- key_ready  out  1  scheduler idle; can accept a key
- subkey  out  48  round subkey (PC-2 output); bit 47 = DES bit 1
- subkey_round  out  4  round index 0..15 of the presented subkey
- subkey_last  out  1  high with round 15
- subkey_valid  out  1  subkey/subkey_round/subkey_last valid
- subkey_ready  in  1  downstream accepts subkey

Behaviour:
- Reset (RESET_N low at a clock edge):
  - state=IDLE, key_ready=1, subkey_valid=0, subkey=0, subkey_round=0, subkey_last=0, C=D=0.
  - Reset mid-operation aborts the job; no further subkeys are emitted.
- State machine, one-hot or encoded:
  - IDLE: key_ready=1. Accept on key_valid&key_ready.
    - C <= PC1(key_in)[55:28], D <= PC1(key_in)[27:0], mode <= key_decrypt, round counter r <= 0.
    - Go to GEN. No other transition.
  - GEN: key_ready=0. Compute the first subkey and register it.
    - subkey_valid<=1, subkey_round<=0. Go to OUT.
  - OUT: subkey_valid=1. Outputs hold stable while subkey_ready=0 (stall of any length).
    - On subkey_valid&subkey_ready with r<15: advance C/D, r<=r+1, register the next subkey the same edge. No bubble; valid stays 1.
    - On handshake with r=15 (subkey_last=1): subkey_valid<=0, key_ready<=1, go to IDLE.
- Shift table S[r], r=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt mode:
  - Output index i (0..15) = PC2(C_i,D_i).
  - C_i/D_i = C_{i-1}/D_{i-1} rotated left by S[i+1], each half independently (28-bit rotate).
  - The first rotation (by S[1]) is applied in GEN before registering.
- Decrypt mode:
  - Output index 0 = PC2(C0,D0) (total left shift 28 returns to origin), i.e. K16.
  - Each subsequent output rotates C/D right by S[17-i] for output i=1..15, i.e. 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - This yields K16..K1.
- Latency:
  - Key accepted at edge T; first subkey valid after edge T+1.
  - With subkey_ready held 1, the 16 subkeys occupy 16 consecutive cycles.
  - key_ready returns after the edge of the last handshake.
  - Minimum 18 cycles per key.
- Ordering and overlap:
  - key_valid while busy is ignored; the key is not consumed.
  - key_decrypt is latched only at acceptance.
  - Only one job is in flight.
- Timing: PC-1/PC-2 are pure wiring. Rotation is a 3-way mux per half (0/1/2 with direction). No combinational path from subkey_ready to subkey_valid or key_ready; all outputs are registered.

Test Plan:
- Reset then key_in=64'h133457799BBCDFF1, decrypt=0, subkey_ready=1 -> round 0 subkey=48'h1B02EFFC7072; round 15 subkey=48'hCB3D8B0E17F5 with subkey_last=1; 16 contiguous valid cycles; key_ready high the next cycle.
- Same key, decrypt=1 -> round 0 subkey=48'hCB3D8B0E17F5, round 15 subkey=48'h1B02EFFC7072; full sequence equals the encrypt sequence reversed (scoreboard vs software model).
- key_in=64'h0 -> all 16 subkeys 0. key_in=64'hFFFFFFFFFFFFFFFF -> all subkeys 48'hFFFFFFFFFFFF. Parity bits flipped (key_in ^ 64'h0101010101010101) -> identical subkeys.
- Random subkey_ready throttling (stalls of 1..5 cycles, including at round 0 and round 15) -> subkey/subkey_round stable during stalls; no duplicate or skipped rounds; key_valid pulses while busy not accepted.
- RESET_N low for one cycle during round 7 -> next cycle subkey_valid=0, key_ready=1; a new key afterwards produces a correct round-0 subkey.
- Back-to-back keys with key_valid held high -> second key accepted exactly one cycle after the first job's last handshake; both sequences are correct.

Source files
------------

// File: rtl/des_key_scheduler_if.sv
// rtl/des_key_scheduler_if.sv - key intake and subkey stream handshake bundle for the DES key scheduler

interface des_key_scheduler_if;
    logic [63:0] key_in;
    logic        key_decrypt;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_last;
    logic        subkey_valid;
    logic        subkey_ready;

    modport master (
        output key_in, key_decrypt, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_round, subkey_last, subkey_valid
    );

    modport slave (
        input  key_in, key_decrypt, key_valid, subkey_ready,
        output key_ready, subkey, subkey_round, subkey_last, subkey_valid
    );
endinterface

// File: rtl/des_key_scheduler.sv
// rtl/des_key_scheduler.sv - DES key schedule sequencer streaming 16 PC-2 subkeys in encrypt or decrypt order

module des_key_scheduler (
    input  logic                   CLK,
    input  logic                   RESET_N,
    des_key_scheduler_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

    state_t      state, state_nxt;
    logic [27:0] c_q, d_q, c_rot, d_rot;
    logic        mode_q;
    logic [3:0]  round_q;
    logic [47:0] subkey_q;
    logic        subkey_valid_q, subkey_last_q, key_ready_q;
    logic        accept, load, adv, done;
    logic [1:0]  rot_amt;
    logic        rot_left;
    logic [55:0] pc1_key;
    logic        unused_parity;

    // PC-1: DES bit j of the key lives at k[64-j]; result is {C, D} with C in [55:28]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
                k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
                k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
                k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
                k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
                k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
                k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
                k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
    endfunction

    // PC-2: CD position j lives at cd[56-j]; result bit 47 is subkey bit 1
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
                cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
                cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
                cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
                cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
                cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
    endfunction

    // Shift table S[1..16]; rounds 1, 2, 9 and 16 shift by one, the rest by two
    function automatic logic [1:0] shift_of(input logic [4:0] n);
        case (n)
            5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt, input logic left);
        case (amt)
            2'd1:    return left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
            2'd2:    return left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    assign pc1_key       = pc1(bus.key_in);
    assign unused_parity = ^{bus.key_in[56], bus.key_in[48], bus.key_in[40], bus.key_in[32],
                             bus.key_in[24], bus.key_in[16], bus.key_in[8],  bus.key_in[0]};

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and datapath strobes; key_ready is a registered copy of IDLE so accept needs only key_valid
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.key_valid) begin
                accept    = 1'b1;
                state_nxt = GEN;
            end
            GEN: begin
                load      = 1'b1;
                state_nxt = OUT;
            end
            OUT: if (bus.subkey_ready) begin
                if (round_q == 4'd15) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    adv = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Rotation select: encrypt leads by S[r+2] to the next round, decrypt walks back by S[16-r];
    // decrypt starts at C0/D0 because the full 28-bit tour returns to the origin
    always_comb begin
        rot_amt  = 2'd0;
        rot_left = 1'b1;
        if (state == GEN) begin
            rot_amt = mode_q ? 2'd0 : 2'd1;
        end else if (mode_q) begin
            rot_amt  = shift_of(5'd16 - {1'b0, round_q});
            rot_left = 1'b0;
        end else begin
            rot_amt = shift_of({1'b0, round_q} + 5'd2);
        end
        c_rot = rot28(c_q, rot_amt, rot_left);
        d_rot = rot28(d_q, rot_amt, rot_left);
    end

    // Key halves, round counter and registered subkey stream outputs
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            c_q            <= '0;
            d_q            <= '0;
            mode_q         <= 1'b0;
            round_q        <= '0;
            subkey_q       <= '0;
            subkey_valid_q <= 1'b0;
            subkey_last_q  <= 1'b0;
            key_ready_q    <= 1'b1;
        end else begin
            if (accept) begin
                c_q         <= pc1_key[55:28];
                d_q         <= pc1_key[27:0];
                mode_q      <= bus.key_decrypt;
                round_q     <= '0;
                key_ready_q <= 1'b0;
            end
            if (load || adv) begin
                c_q            <= c_rot;
                d_q            <= d_rot;
                subkey_q       <= pc2({c_rot, d_rot});
                subkey_valid_q <= 1'b1;
            end
            if (load) begin
                round_q       <= '0;
                subkey_last_q <= 1'b0;
            end
            if (adv) begin
                round_q       <= round_q + 4'd1;
                subkey_last_q <= (round_q == 4'd14);
            end
            if (done) begin
                subkey_valid_q <= 1'b0;
                subkey_last_q  <= 1'b0;
                key_ready_q    <= 1'b1;
            end
        end
    end

    assign bus.key_ready    = key_ready_q;
    assign bus.subkey       = subkey_q;
    assign bus.subkey_round = round_q;
    assign bus.subkey_last  = subkey_last_q;
    assign bus.subkey_valid = subkey_valid_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb/tb_des_key_scheduler.sv - directed self-checking bench for des_key_scheduler

module tb_des_key_scheduler;

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    des_key_scheduler_if bus();

    des_key_scheduler dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = reference key encrypt, 1 = reference key decrypt, 2 = all zero, 3 = all ones
    function automatic logic [47:0] expk(input int kind, input int idx);
        case (kind)
            0:       return ktab[idx];
            1:       return ktab[15 - idx];
            2:       return 48'h0;
            default: return 48'hFFFFFFFFFFFF;
        endcase
    endfunction

    // Called at a negedge with the scheduler idle; leaves it idle (or accepting next_key when hold_next)
    task automatic run_job(input logic [63:0] key, input logic dec, input int kind, input bit stall,
                           input bit hold_next, input logic [63:0] next_key, input logic next_dec);
        logic [47:0] e;
        int n;
        chk("key_ready_idle", 64'(bus.key_ready), 64'd1);
        bus.key_in       = key;
        bus.key_decrypt  = dec;
        bus.key_valid    = 1'b1;
        bus.subkey_ready = 1'b1;
        @(negedge CLK);
        chk("key_ready_busy", 64'(bus.key_ready), 64'd0);
        chk("gen_valid_low", 64'(bus.subkey_valid), 64'd0);
        if (hold_next) begin
            bus.key_in      = next_key;
            bus.key_decrypt = next_dec;
        end else begin
            bus.key_valid   = 1'b0;
            bus.key_in      = ~key;
            bus.key_decrypt = ~dec;
        end
        @(negedge CLK);
        for (int idx = 0; idx < 16; idx++) begin
            e = expk(kind, idx);
            chk($sformatf("valid_r%0d", idx), 64'(bus.subkey_valid), 64'd1);
            chk($sformatf("subkey_r%0d", idx), 64'(bus.subkey), 64'(e));
            chk($sformatf("round_r%0d", idx), 64'(bus.subkey_round), 64'(idx));
            chk($sformatf("last_r%0d", idx), 64'(bus.subkey_last), 64'(idx == 15));
            if (stall && (idx == 0 || idx == 15 || $urandom_range(0, 2) == 0)) begin
                n = $urandom_range(1, 5);
                bus.subkey_ready = 1'b0;
                for (int s = 0; s < n; s++) begin
                    if (!hold_next) bus.key_valid = 1'($urandom_range(0, 1));
                    @(negedge CLK);
                    chk($sformatf("stall_valid_r%0d", idx), 64'(bus.subkey_valid), 64'd1);
                    chk($sformatf("stall_subkey_r%0d", idx), 64'(bus.subkey), 64'(e));
                    chk($sformatf("stall_round_r%0d", idx), 64'(bus.subkey_round), 64'(idx));
                    chk($sformatf("stall_busy_r%0d", idx), 64'(bus.key_ready), 64'd0);
                end
                if (!hold_next) bus.key_valid = 1'b0;
                bus.subkey_ready = 1'b1;
            end
            @(negedge CLK);
        end
        chk("done_valid_low", 64'(bus.subkey_valid), 64'd0);
        chk("done_key_ready", 64'(bus.key_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N          = 1'b0;
        bus.key_in       = '0;
        bus.key_decrypt  = 1'b0;
        bus.key_valid    = 1'b0;
        bus.subkey_ready = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
        chk("rst_subkey", 64'(bus.subkey), 64'd0);
        chk("rst_round", 64'(bus.subkey_round), 64'd0);
        chk("rst_last", 64'(bus.subkey_last), 64'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        run_job(KEY, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_job(KEY, 1'b1, 1, 1'b0, 1'b0, '0, 1'b0);
        run_job(64'h0, 1'b0, 2, 1'b0, 1'b0, '0, 1'b0);
        run_job(64'hFFFFFFFFFFFFFFFF, 1'b1, 3, 1'b0, 1'b0, '0, 1'b0);
        run_job(KEY ^ 64'h0101010101010101, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);
        run_job(KEY, 1'b0, 0, 1'b1, 1'b0, '0, 1'b0);
        run_job(KEY, 1'b1, 1, 1'b1, 1'b0, '0, 1'b0);

        // abort mid-job with a one-cycle reset while round 7 is presented
        bus.key_in      = KEY;
        bus.key_decrypt = 1'b0;
        bus.key_valid   = 1'b1;
        @(negedge CLK);
        bus.key_valid = 1'b0;
        @(negedge CLK);
        repeat (7) @(negedge CLK);
        chk("abort_pre_round", 64'(bus.subkey_round), 64'd7);
        chk("abort_pre_subkey", 64'(bus.subkey), 64'(ktab[7]));
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("abort_valid", 64'(bus.subkey_valid), 64'd0);
        chk("abort_key_ready", 64'(bus.key_ready), 64'd1);
        chk("abort_subkey", 64'(bus.subkey), 64'd0);
        repeat (2) @(negedge CLK);
        chk("abort_stays_idle", 64'(bus.subkey_valid), 64'd0);
        run_job(KEY, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);

        // back-to-back: key_valid held across the first job
        run_job(KEY, 1'b0, 0, 1'b0, 1'b1, KEY, 1'b1);
        run_job(KEY, 1'b1, 1, 1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
